// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 32;
  localparam int unsigned DATA_W_DEF       = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned MAX_WAIT_DEF     = 15;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_e;

  // Bits needed to hold a counter value in 0..max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and stall signals of the arbiter; master = arbiter side,
// slave = the requesters plus the memory that sit around it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W/8-1:0] d_wstrb;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_done;
  logic [DATA_W-1:0]   d_rdata;

  logic                mem_req;
  logic                mem_gnt;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  logic stall_read;
  logic mem_err;

  modport master (
    input  if_req, if_addr,
    output if_done, if_rdata,
    input  d_req, d_we, d_addr, d_wstrb, d_wdata,
    output d_done, d_rdata,
    output mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output stall_read, mem_err
  );

  modport slave (
    output if_req, if_addr,
    input  if_done, if_rdata,
    output d_req, d_we, d_addr, d_wstrb, d_wdata,
    input  d_done, d_rdata,
    input  mem_req, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  stall_read, mem_err
  );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// Data-first requester selection with a saturating fetch starvation counter.
// Combinational select; the counter updates on the grant edge.
module mem_arb_prio_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   if_req,
  input  logic   if_done,
  input  logic   d_req,
  input  logic   d_done,
  input  logic   arb_en,
  output owner_e sel
);

  localparam int unsigned CW = cnt_w(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          f_elig;
  logic          d_elig;
  logic          starved;

  // A requester still holding req in its own done cycle is not a new request.
  assign f_elig  = if_req & ~if_done;
  assign d_elig  = d_req & ~d_done;
  assign starved = (starve_cnt == CW'(STARVE_LIMIT));

  always_comb begin
    sel = OWN_NONE;
    if (arb_en) begin
      if (f_elig && (!d_elig || starved)) begin
        sel = OWN_FETCH;
      end else if (d_elig) begin
        sel = OWN_DATA;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (sel == OWN_FETCH) begin
      starve_cnt <= '0;
    end else if (sel == OWN_DATA) begin
      if (!f_elig) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data (data first, fetch starvation guard); done 3 cycles after req at best.
// Held requests wait on mem_gnt/mem_rvalid; MEM_ARB_TIMEOUT_EN adds a response timeout with mem_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned MAX_WAIT     = MAX_WAIT_DEF
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  state_e state;
  state_e state_nxt;
  owner_e owner;
  owner_e sel;

  logic arb_en;
  logic latch;
  logic fin;
  logic fin_err;
  logic timeout;

  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                if_done_q;
  logic                d_done_q;

  // The completion cycle is a turnaround: the requester that just finished can
  // re-present next cycle and be weighed against fetch by the starve counter.
  assign arb_en = (state == ST_IDLE) && !if_done_q && !d_done_q;

  mem_arb_prio_sel #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk    (clk),
    .reset  (reset),
    .if_req (bus.if_req),
    .if_done(if_done_q),
    .d_req  (bus.d_req),
    .d_done (d_done_q),
    .arb_en (arb_en),
    .sel    (sel)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = cnt_w(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_err_q;

  // Fires in the RESP cycle that would bring the count to MAX_WAIT.
  assign timeout = (wait_cnt == WAIT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != ST_RESP) begin
      wait_cnt <= '0;
    end else if (!bus.mem_rvalid) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= fin_err;
    end
  end

  assign bus.mem_err = mem_err_q;
`else
  logic unused_max_wait;

  assign unused_max_wait = (MAX_WAIT != 0);
  assign timeout         = 1'b0;
  assign bus.mem_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    fin       = 1'b0;
    fin_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel != OWN_NONE) begin
          latch     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.mem_rvalid) begin
          fin       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (timeout) begin
          fin       = 1'b1;
          fin_err   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= OWN_NONE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      if_done_q <= fin && (owner == OWN_FETCH);
      d_done_q  <= fin && (owner == OWN_DATA);
      if (fin && (owner == OWN_FETCH)) begin
        if_rdata_q <= fin_err ? '0 : bus.mem_rdata;
      end
      if (fin && (owner == OWN_DATA)) begin
        d_rdata_q <= fin_err ? '0 : bus.mem_rdata;
      end
      if (latch) begin
        owner <= sel;
        if (sel == OWN_FETCH) begin
          addr_q  <= bus.if_addr;
          we_q    <= 1'b0;
          wstrb_q <= '0;
          wdata_q <= '0;
        end else begin
          addr_q  <= bus.d_addr;
          we_q    <= bus.d_we;
          wstrb_q <= bus.d_wstrb;
          wdata_q <= bus.d_wdata;
        end
      end else if (fin) begin
        owner <= OWN_NONE;
      end
    end
  end

  assign bus.mem_req   = (state == ST_REQ);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_done    = d_done_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.stall_read = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, collision, starvation, store hold, reset, timeout.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4),
    .MAX_WAIT    (15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_mem_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.mem_req) seen = 1'b1;
      else tick();
    end
    check_val(tag, 64'(seen), 64'd1);
  endtask

  // Called in a REQ cycle; returns in the completion (done) cycle.
  task automatic serve(input logic [31:0] rd);
    bus.mem_gnt    = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = rd;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit early;
    reset          = 1'b1;
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wstrb    = '0;
    bus.d_wdata    = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;

    repeat (2) tick();
    check_val("rst_outputs",
              {bus.mem_req, bus.if_done, bus.d_done, bus.mem_we, bus.mem_err, bus.stall_read},
              6'b0);
    check_val("rst_rdata", {bus.if_rdata, bus.d_rdata}, 64'd0);
    check_val("rst_mem_fields", {bus.mem_addr[23:0], bus.mem_wstrb, bus.mem_wdata}, 60'd0);
    check_val("rst_state", 64'(dut.state), 64'(ST_IDLE));
    reset = 1'b0;
    tick();

    // Single fetch, minimum latency.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1;
    check_val("fetch_stall_c0", bus.stall_read, 1'b1);
    check_val("fetch_memreq_c0", bus.mem_req, 1'b0);
    tick();
    check_val("fetch_memreq_c1", bus.mem_req, 1'b1);
    check_val("fetch_addr_c1", bus.mem_addr, 32'h100);
    check_val("fetch_we_wstrb_c1", {bus.mem_we, bus.mem_wstrb}, 5'b0);
    check_val("fetch_stall_c1", bus.stall_read, 1'b1);
    serve(32'hDEADBEEF);
    check_val("fetch_done_c3", bus.if_done, 1'b1);
    check_val("fetch_rdata_c3", bus.if_rdata, 32'hDEADBEEF);
    check_val("fetch_stall_c3", bus.stall_read, 1'b0);
    check_val("fetch_memreq_c3", bus.mem_req, 1'b0);
    tick();
    bus.if_req = 1'b0;
    #1;
    check_val("fetch_done_pulse", bus.if_done, 1'b0);
    repeat (2) tick();
    check_val("fetch_no_regrant", bus.mem_req, 1'b0);

    // Collision: data load first, then fetch.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h200;
    tick();
    check_val("col_first_addr", bus.mem_addr, 32'h200);
    check_val("col_first_we", bus.mem_we, 1'b0);
    serve(32'h5555AAAA);
    check_val("col_d_done", {bus.d_done, bus.if_done}, 2'b10);
    check_val("col_d_rdata", bus.d_rdata, 32'h5555AAAA);
    check_val("col_stall_mid", bus.stall_read, 1'b1);
    tick();
    bus.d_req = 1'b0;
    wait_mem_req("col_fetch_req");
    check_val("col_second_addr", bus.mem_addr, 32'h100);
    check_val("col_stall_wait", bus.stall_read, 1'b1);
    serve(32'h0BADF00D);
    check_val("col_if_done", bus.if_done, 1'b1);
    check_val("col_if_rdata", bus.if_rdata, 32'h0BADF00D);
    check_val("col_stall_end", bus.stall_read, 1'b0);
    tick();
    bus.if_req = 1'b0;
    tick();

    // Starvation: four data grants, forced fetch, then data again.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h300;
    for (int g = 0; g < 6; g++) begin
      wait_mem_req($sformatf("starve_req%0d", g));
      check_val($sformatf("starve_grant%0d", g), bus.mem_addr, (g == 4) ? 32'h100 : 32'h300);
      if (g == 3) check_val("starve_cnt_sat", 64'(dut.u_sel.starve_cnt), 64'd4);
      if (g == 4) check_val("starve_cnt_clr", 64'(dut.u_sel.starve_cnt), 64'd0);
      serve(32'(g));
      if (g == 4) begin
        tick();
        bus.if_req = 1'b0;
      end
    end
    check_val("starve_cnt_end", 64'(dut.u_sel.starve_cnt), 64'd0);
    tick();
    bus.d_req = 1'b0;
    tick();

    // Store: latched fields stay stable while gnt is withheld.
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h40;
    bus.d_wstrb = 4'h3;
    bus.d_wdata = 32'h1234;
    wait_mem_req("store_req");
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'hFFC;
    bus.d_wstrb = 4'hF;
    bus.d_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("store_hold%0d", i),
                {bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr[15:0], bus.mem_wdata},
                {1'b1, 1'b1, 4'h3, 16'h0040, 32'h00001234});
      tick();
    end
    serve(32'h0);
    check_val("store_done", {bus.d_done, bus.if_done}, 2'b10);
    tick();
    bus.d_req = 1'b0;
    tick();

    // Reset while waiting for the response; late rvalid must be ignored.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h180;
    wait_mem_req("rst_mid_req");
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    reset       = 1'b1;
    bus.if_req  = 1'b0;
    #1;
    check_val("rst_mid_state", 64'(dut.state), 64'(ST_IDLE));
    tick();
    reset = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFE;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    check_val("rst_late_rvalid", {bus.if_done, bus.d_done, bus.mem_req}, 3'b0);
    check_val("rst_late_rdata", bus.if_rdata, 32'h0);
    check_val("rst_late_state", 64'(dut.state), 64'(ST_IDLE));
    tick();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h104;
    wait_mem_req("rst_next_req");
    check_val("rst_next_addr", bus.mem_addr, 32'h104);
    serve(32'h11112222);
    check_val("rst_next_done", bus.if_done, 1'b1);
    check_val("rst_next_rdata", bus.if_rdata, 32'h11112222);
    tick();
    bus.if_req = 1'b0;
    tick();

    // Long response wait.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h1C0;
    wait_mem_req("wait_req");
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (bus.if_done || bus.mem_err) early = 1'b1;
      if (i < 14) tick();
    end
    check_val("to_no_early", 64'(early), 64'd0);
    tick();
    check_val("to_done", {bus.if_done, bus.mem_err}, 2'b11);
    check_val("to_rdata", bus.if_rdata, 32'h0);
    tick();
    check_val("to_pulse", {bus.if_done, bus.mem_err}, 2'b00);
`else
    early = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus.if_done || bus.mem_err) early = 1'b1;
      tick();
    end
    check_val("wait_no_done", 64'(early), 64'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777;
    tick();
    bus.mem_rvalid = 1'b0;
    check_val("wait_done", {bus.if_done, bus.mem_err}, 2'b10);
    check_val("wait_rdata", bus.if_rdata, 32'h7777);
`endif
    bus.if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
